// File: rtl/bench_slot_scheduler_pkg.sv
// bench_sched_pkg: shared FSM state type and default sizes for the slot scheduler
// Contents: state_t (IDLE, SETTLE, DWELL, ADVANCE), NUM_SLOTS_D, SEL_W_D, GUARD_D
package bench_sched_pkg;
  localparam int NUM_SLOTS_D = 8;
  localparam int SEL_W_D = 3;
  localparam int GUARD_D = 2;
  typedef enum logic [1:0] {IDLE, SETTLE, DWELL, ADVANCE} state_t;
endpackage

// File: rtl/bench_slot_scheduler_rr_next_slot.sv
// rr_next_slot: finds the first set mask bit in rotated priority order
// Ports: mask (eligible slots), base (search origin), include_base (1 = start at base,
//        0 = start at base+1 and check base last), next (found slot), found (any bit set)
module rr_next_slot import bench_sched_pkg::*; #(
  parameter int N = NUM_SLOTS_D,
  parameter int W = SEL_W_D
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] base,
  input  logic         include_base,
  output logic [W-1:0] next,
  output logic         found
);
  logic [W-1:0] w_start;
  logic [W-1:0] w_idx;
  always_comb begin
    w_start = include_base ? base : base + 1'b1;
    w_idx = '0;
    next = '0;
    found = 1'b0;
    // Scan from the farthest offset down so the nearest hit is written last;
    // W-bit index arithmetic wraps modulo N.
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = w_start + W'(i);
      if (mask[w_idx]) begin
        next = w_idx;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bench_slot_scheduler.sv
// bench_slot_scheduler: sequences the benchmark output mux with guard cycles and dwell snapshots
// Inputs:  clk, reset_n (async, active-low), mode (1 = auto round-robin), manual_sel,
//          slot_mask, dwell (0 acts as 1), hold (freezes dwell), data_in (mux output)
// Outputs: sel, slot_en (one-hot during dwell/advance), switch_pulse, settle,
//          snapshot, snapshot_valid (all registered)
module bench_slot_scheduler import bench_sched_pkg::*; #(
  parameter int NUM_SLOTS = NUM_SLOTS_D,
  parameter int SEL_W = SEL_W_D,
  parameter int DWELL_W = 8,
  parameter int GUARD = GUARD_D
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     manual_sel,
  input  logic [NUM_SLOTS-1:0] slot_mask,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic                 hold,
  input  logic [7:0]           data_in,
  output logic [SEL_W-1:0]     sel,
  output logic [NUM_SLOTS-1:0] slot_en,
  output logic                 switch_pulse,
  output logic                 settle,
  output logic [7:0]           snapshot,
  output logic                 snapshot_valid
);
  localparam int GW = $clog2(GUARD + 1);
  state_t               r_state;
  logic [SEL_W-1:0]     r_sel;
  logic [NUM_SLOTS-1:0] r_slot_en;
  logic                 r_switch_pulse;
  logic                 r_settle;
  logic [7:0]           r_snapshot;
  logic                 r_snap_valid;
  logic [DWELL_W-1:0]   r_cnt;
  logic [GW-1:0]        r_guard;
  logic [SEL_W-1:0]     w_base;
  logic [SEL_W-1:0]     w_next;
  logic                 w_found;
  logic                 w_cur_ok;
  logic                 w_man_chg;
  logic                 w_switch;
  logic [SEL_W-1:0]     w_tgt;
  logic [DWELL_W-1:0]   w_dwell_ld;
  logic [NUM_SLOTS-1:0] w_onehot;
  rr_next_slot #(.N(NUM_SLOTS), .W(SEL_W)) u_rr (
    .mask(slot_mask),
    .base(w_base),
    .include_base(r_state == IDLE),
    .next(w_next),
    .found(w_found)
  );
  assign w_base = (r_state == IDLE) ? {SEL_W{1'b0}} : r_sel;
  assign w_cur_ok = slot_mask[r_sel];
  assign w_man_chg = !mode && manual_sel != r_sel && slot_mask[manual_sel];
  assign w_tgt = mode ? w_next : manual_sel;
  assign w_dwell_ld = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign w_onehot = NUM_SLOTS'(1) << r_sel;
  // Any transition into SETTLE; a mask abort in DWELL outranks a manual change.
  always_comb
    w_switch = (r_state == IDLE)    ? (mode ? w_found : slot_mask[manual_sel]) :
               (r_state == DWELL)   ? (w_cur_ok && w_man_chg) :
               (r_state == ADVANCE) ? (w_man_chg || (mode && w_next != r_sel)) : 1'b0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_sel <= '0;
      r_slot_en <= '0;
      r_switch_pulse <= 1'b0;
      r_settle <= 1'b0;
      r_snapshot <= '0;
      r_snap_valid <= 1'b0;
      r_cnt <= '0;
      r_guard <= '0;
    end else begin
      r_switch_pulse <= 1'b0;
      r_snap_valid <= 1'b0;
      if (slot_mask == '0) begin
        r_state <= IDLE;
        r_slot_en <= '0;
        r_settle <= 1'b0;
      end else if (w_switch) begin
        r_state <= SETTLE;
        r_sel <= w_tgt;
        r_switch_pulse <= w_tgt != r_sel;
        r_settle <= 1'b1;
        r_slot_en <= '0;
        r_guard <= GW'(GUARD - 1);
      end else
        case (r_state)
          SETTLE:
            if (!w_cur_ok || r_guard == '0) begin
              r_state <= w_cur_ok ? DWELL : ADVANCE;
              r_settle <= 1'b0;
              r_slot_en <= w_onehot;
              r_cnt <= w_dwell_ld;
            end else
              r_guard <= r_guard - 1'b1;
          DWELL:
            if (!w_cur_ok)
              r_state <= ADVANCE;
            else if (!hold) begin
              if (r_cnt == DWELL_W'(1)) begin
                r_snapshot <= data_in;
                r_snap_valid <= 1'b1;
                r_state <= ADVANCE;
              end else
                r_cnt <= r_cnt - 1'b1;
            end
          ADVANCE:
            // Auto mode reaching here means the same slot won again; a manual
            // slot that lost its mask bit has nowhere to go but IDLE.
            if (mode || w_cur_ok) begin
              r_state <= DWELL;
              r_cnt <= w_dwell_ld;
            end else begin
              r_state <= IDLE;
              r_slot_en <= '0;
            end
          default: ;
        endcase
    end
  assign sel = r_sel;
  assign slot_en = r_slot_en;
  assign switch_pulse = r_switch_pulse;
  assign settle = r_settle;
  assign snapshot = r_snapshot;
  assign snapshot_valid = r_snap_valid;
endmodule

// File: tb/tb_bench_slot_scheduler.sv
// tb_bench_slot_scheduler: randomized scoreboard bench with a behavioural scheduler model
module tb_bench_slot_scheduler;
  localparam int GUARD = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mode = 1'b0;
  logic hold = 1'b0;
  logic [2:0] manual_sel = '0;
  logic [7:0] slot_mask = '0;
  logic [7:0] dwell = '0;
  logic [7:0] data_in = '0;
  logic [2:0] sel;
  logic [7:0] slot_en;
  logic switch_pulse;
  logic settle;
  logic [7:0] snapshot;
  logic snapshot_valid;
  int checks = 0;
  int errors = 0;
  int n_snap = 0;
  always #5 clk = ~clk;
  bench_slot_scheduler dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .manual_sel(manual_sel),
    .slot_mask(slot_mask), .dwell(dwell), .hold(hold), .data_in(data_in),
    .sel(sel), .slot_en(slot_en), .switch_pulse(switch_pulse), .settle(settle),
    .snapshot(snapshot), .snapshot_valid(snapshot_valid)
  );
  typedef struct {logic [2:0] sel; logic [7:0] en; logic st;} stat_t;
  stat_t stq[$];
  logic [2:0] swq[$];
  logic [7:0] snq[$];
  stat_t se;
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", n, a, e, $time);
    end
  endfunction
  // Reference model: phase 0 idle, 1 guard, 2 dwell, 3 advance.
  int ph = 0;
  int g = 0;
  int c = 0;
  int t = 0;
  int ms = 0;
  bit mchg;
  function automatic int first_set(logic [7:0] m, int start);
    for (int i = 0; i < 8; i++)
      if (m[(start + i) % 8]) return (start + i) % 8;
    return -1;
  endfunction
  function automatic int dl();
    return (dwell == 0) ? 1 : int'(dwell);
  endfunction
  function automatic void go(int tg);
    if (tg != ms) swq.push_back(3'(tg));
    ms = tg;
    ph = 1;
    g = GUARD;
  endfunction
  always @(posedge clk) begin
    if (!reset_n) begin
      ph = 0;
      ms = 0;
    end else begin
      mchg = !mode && int'(manual_sel) != ms && slot_mask[manual_sel];
      if (slot_mask == 0) ph = 0;
      else
        case (ph)
          0: begin
            t = mode ? first_set(slot_mask, 0) : (slot_mask[manual_sel] ? int'(manual_sel) : -1);
            if (t >= 0) go(t);
          end
          1: if (!slot_mask[ms]) ph = 3;
             else begin
               g = g - 1;
               if (g == 0) begin ph = 2; c = dl(); end
             end
          2: if (!slot_mask[ms]) ph = 3;
             else if (mchg) go(int'(manual_sel));
             else if (!hold) begin
               if (c == 1) begin snq.push_back(data_in); ph = 3; end
               else c = c - 1;
             end
          default: if (mchg) go(int'(manual_sel));
             else if (mode) begin
               t = first_set(slot_mask, ms + 1);
               if (t == ms) begin ph = 2; c = dl(); end
               else go(t);
             end else if (slot_mask[ms]) begin ph = 2; c = dl(); end
             else ph = 0;
        endcase
      stq.push_back(stat_t'{3'(ms), (ph >= 2) ? 8'(1 << ms) : 8'h00, ph == 1});
    end
  end
  always @(negedge clk)
    if (reset_n) begin
      if (stq.size() == 0) chk("status_queue_empty", 1, 0);
      else begin
        se = stq.pop_front();
        chk("sel", sel, se.sel);
        chk("slot_en", slot_en, se.en);
        chk("settle", settle, se.st);
      end
      if (switch_pulse) begin
        if (swq.size() == 0) chk("unexpected_switch_pulse", 1, 0);
        else chk("switch_sel", sel, swq.pop_front());
      end
      if (snapshot_valid) begin
        n_snap++;
        if (snq.size() == 0) chk("unexpected_snapshot_valid", 1, 0);
        else chk("snapshot", snapshot, snq.pop_front());
      end
    end
  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      data_in = 8'($urandom);
    end
  endtask
  task automatic chk_reset_outputs(string tag);
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_slot_en"}, slot_en, 0);
    chk({tag, "_switch_pulse"}, switch_pulse, 0);
    chk({tag, "_settle"}, settle, 0);
    chk({tag, "_snapshot"}, snapshot, 0);
    chk({tag, "_snapshot_valid"}, snapshot_valid, 0);
  endtask
  bit found;
  initial begin
    tick(2);
    chk_reset_outputs("reset");
    #1 reset_n = 1'b1;
    mode = 1'b1; slot_mask = 8'hA4; dwell = 8'd3;
    tick(40);
    slot_mask = 8'h10; dwell = 8'd4;
    tick(30);
    mode = 1'b0; slot_mask = 8'hFF; manual_sel = 3'd1;
    tick(12);
    manual_sel = 3'd6;
    tick(10);
    slot_mask = 8'hF7; manual_sel = 3'd3;
    tick(12);
    dwell = 8'd2;
    tick(3); hold = 1'b1; tick(5); hold = 1'b0; tick(6);
    repeat (20) begin hold = 1'($urandom_range(0, 1)); tick(1); end
    hold = 1'b0;
    dwell = 8'd0; tick(12);
    dwell = 8'd1; tick(12);
    mode = 1'b1; slot_mask = 8'hA4; dwell = 8'd3;
    tick(9);
    slot_mask = 8'h00; tick(3);
    slot_mask = 8'h01; tick(15);
    repeat (400) begin
      if ($urandom_range(0, 15) == 0) mode = 1'($urandom);
      if ($urandom_range(0, 7) == 0) manual_sel = 3'($urandom);
      if ($urandom_range(0, 19) == 0) slot_mask = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 9) == 0) dwell = 8'($urandom_range(0, 5));
      hold = ($urandom_range(0, 3) == 0);
      tick(1);
    end
    mode = 1'b1; slot_mask = 8'h66; dwell = 8'd2; hold = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (settle) found = 1'b1;
    end
    chk("settle_reached_before_async_reset", found, 1);
    #2 reset_n = 1'b0;
    stq.delete(); swq.delete(); snq.delete();
    #1 chk_reset_outputs("async_reset");
    tick(2);
    #1 reset_n = 1'b1;
    tick(3);
    chk("restart_lowest_slot", sel, 1);
    tick(20);
    #2;
    chk("pending_switch_events", swq.size(), 0);
    chk("pending_snapshot_events", snq.size(), 0);
    chk("enough_snapshots_seen", n_snap > 10, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
